// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm front end: button indices, the
// per-button conditioner state encoding and default timing at 100 MHz.
package clock_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam int CLK_HZ                  = 100_000_000;
  localparam int DEBOUNCE_CYCLES_DEF     = CLK_HZ / 100;  // 10 ms
  localparam int REPEAT_DELAY_CYCLES_DEF = CLK_HZ / 2;    // 500 ms
  localparam int REPEAT_RATE_CYCLES_DEF  = CLK_HZ / 4;    // 4 Hz

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD_DELAY  = 3'd2,
    ST_HELD_REPEAT = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } btn_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton: 2-flop synchroniser, debounce/auto-repeat FSM sharing a
// single counter, and registered level/press/release/step outputs.
module button_channel
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEF,
  parameter int REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEF,
  parameter bit REPEAT_EN           = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_raw_i,
  output logic               level_o,
  output logic               press_o,
  output logic               release_o,
  output logic               step_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE_CYCLES - 1);

  logic          sync1_q;
  logic          sync_q;
  btn_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_raw_i;
      sync_q    <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync_q) begin
            state_q <= ST_DEB_PRESS;
            cnt_q   <= '0;
          end
        end
        ST_DEB_PRESS: begin
          if (!sync_q) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= ST_HELD_DELAY;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
            step_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HELD_DELAY: begin
          if (!sync_q) begin
            state_q <= ST_DEB_RELEASE;
            cnt_q   <= '0;
          end else if (cnt_q == DELAY_LAST) begin
            // Channels without auto-repeat park here with the counter saturated.
            if (REPEAT_EN) begin
              state_q <= ST_HELD_REPEAT;
              cnt_q   <= '0;
              step_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HELD_REPEAT: begin
          if (!sync_q) begin
            state_q <= ST_DEB_RELEASE;
            cnt_q   <= '0;
          end else if (cnt_q == RATE_LAST) begin
            cnt_q  <= '0;
            step_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DEB_RELEASE: begin
          // A bounce back high restarts the repeat delay without any pulse.
          if (sync_q) begin
            state_q <= ST_HELD_DELAY;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign step_o    = step_q;
  assign state_o   = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Five independent button channels feeding the clock/alarm controller;
// dbg_state packs each channel's FSM state, channel i at [i*3 +: 3].
module button_conditioner
  import clock_pkg::*;
#(
  parameter int                 NUM_BTN             = 5,
  parameter int                 DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
  parameter int                 REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEF,
  parameter int                 REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEF,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK         = 5'b10010
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_raw,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic [NUM_BTN-1:0]         btn_press,
  output logic [NUM_BTN-1:0]         btn_release,
  output logic [NUM_BTN-1:0]         btn_step,
  output logic [NUM_BTN*STATE_W-1:0] dbg_state
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .REPEAT_EN           (REPEAT_MASK[i])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i]),
      .step_o    (btn_step[i]),
      .state_o   (dbg_state[i*STATE_W +: STATE_W])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (debounce 4,
// delay 20, rate 8): per-cycle expectation tables plus reset corner cases.
module tb_button_conditioner;

  localparam int NB = 5;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_step;
  logic [14:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            len;
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] stp;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .NUM_BTN             (NB),
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (20),
    .REPEAT_RATE_CYCLES  (8),
    .REPEAT_MASK         (5'b10010)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_step    (btn_step),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver and checker tasks
  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive raw ahead of the next rising edge and return at the following
  // falling edge, where outputs reflect that rising edge.
  task automatic apply(input logic [NB-1:0] raw);
    btn_raw = raw;
    @(negedge clk);
  endtask

  task automatic add_vec(input int len, input logic [NB-1:0] raw, input logic [NB-1:0] lvl,
                         input logic [NB-1:0] prs, input logic [NB-1:0] rel,
                         input logic [NB-1:0] stp);
    vec_t v;
    v.len = len; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.stp = stp;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int k = 0; k < vecs.size(); k++) begin
      for (int c = 0; c < vecs[k].len; c++) begin
        apply(vecs[k].raw);
        chk($sformatf("%s seg%0d cyc%0d level", tag, k, c), 15'(btn_level), 15'(vecs[k].lvl));
        chk($sformatf("%s seg%0d cyc%0d press", tag, k, c), 15'(btn_press), 15'(vecs[k].prs));
        chk($sformatf("%s seg%0d cyc%0d release", tag, k, c), 15'(btn_release), 15'(vecs[k].rel));
        chk($sformatf("%s seg%0d cyc%0d step", tag, k, c), 15'(btn_step), 15'(vecs[k].stp));
      end
    end
    vecs.delete();
  endtask

  // Masked channels m held 60 cycles from e0, then released.
  task automatic build_hold_repeat(input logic [NB-1:0] m);
    add_vec(6,  m, '0, '0, '0, '0);   // e0..e5
    add_vec(1,  m, m,  m,  '0, m);    // e6 press+step
    add_vec(19, m, m,  '0, '0, '0);   // e7..e25
    add_vec(1,  m, m,  '0, '0, m);    // e26 first repeat
    for (int r = 0; r < 4; r++) begin
      add_vec(7, m, m, '0, '0, '0);
      add_vec(1, m, m, '0, '0, m);    // e34, e42, e50, e58
    end
    add_vec(1,  m,  m,  '0, '0, '0);  // e59
    add_vec(6,  '0, m,  '0, '0, '0);  // e60..e65
    add_vec(1,  '0, '0, '0, m,  '0);  // e66 release
    add_vec(5,  '0, '0, '0, '0, '0);
  endtask

  initial begin
    int press_at;
    reset   = 1'b1;
    btn_raw = '0;
    #12;
    chk("reset level",   15'(btn_level),   15'd0);
    chk("reset press",   15'(btn_press),   15'd0);
    chk("reset release", 15'(btn_release), 15'd0);
    chk("reset step",    15'(btn_step),    15'd0);
    chk("reset state",   dbg_state,        15'd0);
    @(negedge clk);
    reset = 1'b0;

    add_vec(100, '0, '0, '0, '0, '0);
    run_vecs("idle");

    build_hold_repeat(5'b00010);
    run_vecs("hold_u");

    // C bounces 1,0,1,0 (2 cycles each) then stays high 10 cycles.
    add_vec(2, 5'b00001, '0, '0, '0, '0);
    add_vec(2, 5'b00000, '0, '0, '0, '0);
    add_vec(2, 5'b00001, '0, '0, '0, '0);
    add_vec(2, 5'b00000, '0, '0, '0, '0);
    add_vec(6, 5'b00001, '0, '0, '0, '0);
    add_vec(1, 5'b00001, 5'b00001, 5'b00001, '0, 5'b00001);
    add_vec(3, 5'b00001, 5'b00001, '0, '0, '0);
    add_vec(6, 5'b00000, 5'b00001, '0, '0, '0);
    add_vec(1, 5'b00000, '0, '0, 5'b00001, '0);
    add_vec(4, 5'b00000, '0, '0, '0, '0);
    run_vecs("bounce_c");

    // L is unmasked: a 40-cycle hold past the repeat delay yields no steps.
    add_vec(6,  5'b00100, '0, '0, '0, '0);
    add_vec(1,  5'b00100, 5'b00100, 5'b00100, '0, 5'b00100);
    add_vec(33, 5'b00100, 5'b00100, '0, '0, '0);
    add_vec(6,  5'b00000, 5'b00100, '0, '0, '0);
    add_vec(1,  5'b00000, '0, '0, 5'b00100, '0);
    add_vec(4,  5'b00000, '0, '0, '0, '0);
    run_vecs("hold_l");

    build_hold_repeat(5'b10010);
    run_vecs("hold_ud");

    // Release bounce: U held, low for 2 cycles, high again -> no release,
    // repeat delay restarts so first repeat is 20 cycles after sync returns.
    for (int i = 0; i < 10; i++) apply(5'b00010);       // press at e6
    apply(5'b00000); apply(5'b00000);                    // e10,e11 low
    for (int i = 0; i < 4; i++) begin                    // e12..e15
      apply(5'b00010);
      chk($sformatf("rel_bounce level %0d", i), 15'(btn_level), 15'(5'b00010));
      chk($sformatf("rel_bounce release %0d", i), 15'(btn_release), 15'd0);
    end
    // Sync low reaches FSM at e12 (DEB_RELEASE), high again at e14 -> HELD_DELAY cnt 0.
    press_at = -1;
    for (int i = 16; i < 40; i++) begin
      apply(5'b00010);
      if (btn_step[1] && press_at < 0) press_at = i;
    end
    chk("rel_bounce first repeat edge", 15'(press_at), 15'd34);
    for (int i = 0; i < 12; i++) apply('0);

    // Reset in HELD_REPEAT with U still held.
    for (int i = 0; i < 30; i++) apply(5'b00010);
    chk("midhold level before reset", 15'(btn_level), 15'(5'b00010));
    chk("midhold state before reset", dbg_state, 15'(3'd3 << 3));
    #2 reset = 1'b1;
    #1;
    chk("midhold level at reset", 15'(btn_level), 15'd0);
    chk("midhold step at reset",  15'(btn_step),  15'd0);
    chk("midhold state at reset", dbg_state,      15'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("midhold release in reset %0d", i), 15'(btn_release), 15'd0);
    end
    reset = 1'b0;
    press_at = -1;
    for (int i = 0; i < 20; i++) begin
      apply(5'b00010);
      chk($sformatf("post reset release %0d", i), 15'(btn_release), 15'd0);
      if (btn_press[1] && press_at < 0) begin
        press_at = i;
        chk("post reset press mask", 15'(btn_press), 15'(5'b00010));
      end
      if (press_at < 0)
        chk($sformatf("post reset level %0d", i), 15'(btn_level), 15'd0);
    end
    chk("post reset press edge", 15'(press_at), 15'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
